keypad_encoder: RTL and testbench
=================================

Name: keypad_encoder

Overview:
- Scans a 4-row x 5-column active-low key matrix and debounces the result.
- Emits one 5-bit key code with a single-cycle strobe per physical key press.
- Output pair (data, cifra_noua) is the key-entry interface of the calculator control FSM:
  - codes 0-9 are digits, 10 enter, 11 plus, 12 minus, 13 produs, 14 divide, 15 factorial, 16 putere, 17 radical, 18 escape.
- Sits between board keypad pins and the calculator core, in the same clock domain as the core.

Parameters:
- SCAN_DIV, 50000, clocks each column is driven before rows are sampled (min 4).
- DEBOUNCE_CNT, 20, consecutive matching row samples required to confirm a press or a release (min 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- row_in  in  4  keypad rows, active-low (external pull-ups), asynchronous to clk
- col_out  out  5  column drives, active-low, exactly one bit low at any time
- data  out  5  last confirmed key code, held until next press
- cifra_noua  out  1  one-clock strobe; data is valid in the same cycle
- key_held  out  1  high while a confirmed key is still down

Behaviour:
- Reset values (on rst low, immediate):
  - col_out=5'b11110; data=0; cifra_noua=0; key_held=0
  - state=SCAN; column index=0; all counters=0
- row_in passes through a 2-flop synchronizer (rows_s). All decisions use rows_s.
- Key index k = col*4 + row. Code = k for k<=18. k=19 is unmapped.
- SCAN:
  - dwell counter counts 0..SCAN_DIV-1 on the current column.
  - At dwell==SCAN_DIV-1 with rows_s==4'b1111: advance column (4 wraps to 0), drive the new col_out, clear dwell.
  - At dwell==SCAN_DIV-1 with exactly one row low: capture row pattern and column, then go to DEBOUNCE with db_cnt=0. Column stays driven.
  - At dwell==SCAN_DIV-1 with two or more rows low (ghost/multi-key): treat as no key and advance column.
- DEBOUNCE:
  - Each cycle rows_s equals the captured pattern: db_cnt++.
  - On a mismatch: return to SCAN and advance column.
  - When db_cnt==DEBOUNCE_CNT-1 and rows_s still matches, go to PRESSED.
    - On that same edge, load data=code and pulse cifra_noua=1 for one cycle; key_held=1.
    - If k==19: no data load and no pulse, but still go to PRESSED (key_held=1).
  - Latency: pulse occurs exactly DEBOUNCE_CNT cycles after the capturing sample edge.
- PRESSED:
  - Column stays frozen. No further strobes regardless of hold time (no auto-repeat).
  - When rows_s==4'b1111: go to RELEASE with db_cnt=0.
- RELEASE:
  - rows_s==4'b1111 for DEBOUNCE_CNT consecutive cycles: key_held=0, then go to SCAN and advance column.
  - Any low row before that: back to PRESSED (bounce). No new strobe.
- Simultaneous events:
  - A second key pressed while in PRESSED/RELEASE is ignored until full release.
  - A second key in another column is not seen, because scanning is frozen.
- cifra_noua is never high on two consecutive cycles.
- data changes only on the cycle cifra_noua is high.
- Reset mid-operation (any state) returns all outputs to reset values immediately. A key held through reset is re-detected as a new press after reset release.
- Counters are sized with clog2(SCAN_DIV) and clog2(DEBOUNCE_CNT); none wraps, all are cleared on state exit.

Decomposition:
- Package keypad_pkg:
  - key code constants (KEY_ENTER=10 … KEY_ESCAPE=18, KEY_NONE=19)
  - state encoding SCAN/DEBOUNCE/PRESSED/RELEASE
  - NUM_ROWS=4, NUM_COLS=5
- Sub-module kp_row_sync: 4-bit 2-flop synchronizer, async active-low reset to 4'b1111.
- Remainder (scan counter, FSM, code map) lives in keypad_encoder.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, keypad model shorts row r to col c while pressed):
- Press key col1,row3 (k=7), hold 100 cycles, release → exactly one cifra_noua pulse with data=7; key_held high from pulse until 3 clean cycles after release; scanning resumes at column 2.
- Press k=18 (col4,row2) with 2-cycle bounce gap during DEBOUNCE → no pulse on first attempt; press re-detected on a later scan; single pulse data=18 (escape).
- Press k=19 → no pulse, data keeps previous value, key_held=1 until release.
- Press rows 0 and 1 together in column 2 → no pulse, col_out keeps rotating 11110→11101→11011→10111→01111→11110.
- Press k=11, then press k=4 while k=11 held, release both → only data=11 strobe; k=4 strobed only if still held after full release.
- Assert rst low during PRESSED (k=5 held) → outputs reset that cycle, col_out=11110; after rst high, k=5 is re-detected with one pulse data=5.

Source files
------------

// File: rtl/keypad_encoder_pkg.sv
// keypad_pkg: shared definitions for the keypad encoder slice.
//   - matrix geometry (NUM_ROWS x NUM_COLS)
//   - key codes seen by the calculator control FSM (0-9 digits, 10..18 operators)
//   - scanner state encoding
//   - small helpers for row-pattern decoding and column drive generation
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 5;

  localparam logic [4:0] KEY_ENTER     = 5'd10;
  localparam logic [4:0] KEY_PLUS      = 5'd11;
  localparam logic [4:0] KEY_MINUS     = 5'd12;
  localparam logic [4:0] KEY_PRODUS    = 5'd13;
  localparam logic [4:0] KEY_DIVIDE    = 5'd14;
  localparam logic [4:0] KEY_FACTORIAL = 5'd15;
  localparam logic [4:0] KEY_PUTERE    = 5'd16;
  localparam logic [4:0] KEY_RADICAL   = 5'd17;
  localparam logic [4:0] KEY_ESCAPE    = 5'd18;
  // Physical position col4,row3 has no function assigned.
  localparam logic [4:0] KEY_NONE      = 5'd19;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  // True when exactly one row line is pulled low.
  function automatic logic single_low(input logic [NUM_ROWS-1:0] rows);
    return ($countones(~rows) == 1);
  endfunction

  // Index of the lowest-numbered low row (only meaningful when one row is low).
  function automatic logic [1:0] low_row(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Active-low one-cold column drive for a column index.
  function automatic logic [NUM_COLS-1:0] col_drive(input logic [2:0] idx);
    return ~(NUM_COLS'(1) << idx);
  endfunction

endpackage

// File: rtl/keypad_encoder_row_sync.sv
// kp_row_sync: two-flop synchronizer for the keypad row lines.
//   clk    : system clock
//   rst    : asynchronous active-low reset; both stages return to "no key" (4'b1111)
//   row_in : raw active-low row lines, asynchronous to clk
//   rows_s : synchronized row lines
module kp_row_sync
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_ROWS-1:0] rows_s
);

  logic [NUM_ROWS-1:0] rows_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rows_p0 <= '1;
      rows_s  <= '1;
    end else begin
      // stage p0: metastability catch; stage p1: stable copy
      rows_p0 <= row_in;
      rows_s  <= rows_p0;
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x5 active-low key matrix, debounces press and
// release, and hands one key code per physical press to the calculator core.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   row_in     : keypad rows, active-low, asynchronous to clk
//   col_out    : column drives, active-low, exactly one bit low
//   data       : last confirmed key code (col*4+row), held until the next press
//   cifra_noua : one-cycle strobe, data valid in the same cycle
//   key_held   : high while a confirmed key is still down
// Parameters:
//   SCAN_DIV     : clocks each column is driven before rows are judged (>=4)
//   DEBOUNCE_CNT : matching samples needed to confirm a press or a release (>=2)
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic [4:0]          data,
  output logic                cifra_noua,
  output logic                key_held
);

  localparam int DW_W = $clog2(SCAN_DIV);
  localparam int DB_W = $clog2(DEBOUNCE_CNT);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [2:0]      COL_LAST   = 3'(NUM_COLS - 1);

  logic [NUM_ROWS-1:0] rows_s;
  kp_state_t           state;
  logic [2:0]          col_idx;
  logic [2:0]          next_col;
  logic [DW_W-1:0]     dwell;
  logic [DB_W-1:0]     db_cnt;
  logic [NUM_ROWS-1:0] cap_rows;
  logic [4:0]          cap_code;

  kp_row_sync u_row_sync (
    .clk    (clk),
    .rst    (rst),
    .row_in (row_in),
    .rows_s (rows_s)
  );

  assign next_col = (col_idx == COL_LAST) ? 3'd0 : col_idx + 3'd1;
  // col*4 + row is exactly the concatenation {col, row[1:0]}.
  assign cap_code = {col_idx, low_row(cap_rows)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SCAN;
      col_idx    <= '0;
      col_out    <= col_drive(3'd0);
      dwell      <= '0;
      db_cnt     <= '0;
      cap_rows   <= '1;
      data       <= '0;
      cifra_noua <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      cifra_noua <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            // Two or more low rows cannot be decoded reliably (ghosting), so
            // they are treated exactly like an idle column.
            if (single_low(rows_s)) begin
              cap_rows <= rows_s;
              db_cnt   <= '0;
              state    <= DEBOUNCE;
            end else begin
              col_idx <= next_col;
              col_out <= col_drive(next_col);
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (rows_s != cap_rows) begin
            db_cnt  <= '0;
            state   <= SCAN;
            col_idx <= next_col;
            col_out <= col_drive(next_col);
          end else if (db_cnt == DB_LAST) begin
            db_cnt   <= '0;
            state    <= PRESSED;
            key_held <= 1'b1;
            if (cap_code != KEY_NONE) begin
              data       <= cap_code;
              cifra_noua <= 1'b1;
            end
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        PRESSED: begin
          // Column stays frozen: other keys are invisible until full release.
          if (rows_s == '1) begin
            db_cnt <= '0;
            state  <= RELEASE;
          end
        end
        RELEASE: begin
          if (rows_s != '1) begin
            db_cnt <= '0;
            state  <= PRESSED;
          end else if (db_cnt == DB_LAST) begin
            db_cnt   <= '0;
            key_held <= 1'b0;
            state    <= SCAN;
            col_idx  <= next_col;
            col_out  <= col_drive(next_col);
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: keypad matrix model + procedural reference scanner,
// per-cycle output comparison and directed/random press scenarios.
module tb_keypad_encoder;
  import keypad_pkg::*;

  localparam int SD = 4;
  localparam int DC = 3;
  localparam logic [4:0] OPS [9] = '{KEY_ENTER, KEY_PLUS, KEY_MINUS, KEY_PRODUS,
                                     KEY_DIVIDE, KEY_FACTORIAL, KEY_PUTERE,
                                     KEY_RADICAL, KEY_ESCAPE};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row_in;
  logic [4:0] col_out;
  logic [4:0] data;
  logic       cifra_noua;
  logic       key_held;
  logic [19:0] keys = '0;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .data       (data),
    .cifra_noua (cifra_noua),
    .key_held   (key_held)
  );

  // Physical matrix: a pressed key shorts its row to its column.
  always_comb begin
    row_in = 4'b1111;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_col;
  logic [4:0] m_data;
  bit         m_stb, m_held, m_in_db, abort;
  logic [3:0] m_s1, m_rs;
  int         m_pulses = 0;

  function automatic logic [3:0] raw_rows(input int col);
    logic [3:0] r4;
    r4 = 4'hF;
    for (int r = 0; r < 4; r++) if (keys[col*4+r]) r4[r] = 1'b0;
    return r4;
  endfunction

  task automatic m_reset();
    m_col = 0; m_data = '0; m_stb = 0; m_held = 0; m_in_db = 0;
    m_s1 = 4'hF; m_rs = 4'hF;
  endtask

  // One clock edge: returns the synchronized rows the scanner judges at this edge.
  task automatic tick(output logic [3:0] rs);
    @(posedge clk or negedge rst);
    if (!rst) begin
      abort = 1;
      rs = 4'hF;
      return;
    end
    rs = m_rs;
    m_rs = m_s1;
    m_s1 = raw_rows(m_col);
    m_stb = 0;
  endtask

  task automatic run_model();
    logic [3:0] rs, cap;
    int lows, row, k, quiet;
    bit ok, done;
    while (!abort) begin
      for (int d = 0; d < SD; d++) begin
        tick(rs);
        if (abort) return;
      end
      lows = 0; row = 0;
      for (int r = 3; r >= 0; r--) if (!rs[r]) begin lows++; row = r; end
      if (lows != 1) begin m_col = (m_col + 1) % 5; continue; end
      cap = rs; m_in_db = 1; ok = 1;
      for (int i = 0; i < DC; i++) begin
        tick(rs);
        if (abort) return;
        if (rs != cap) begin ok = 0; break; end
      end
      m_in_db = 0;
      if (!ok) begin m_col = (m_col + 1) % 5; continue; end
      k = m_col * 4 + row;
      if (k <= 18) begin m_data = 5'(k); m_stb = 1; m_pulses++; end
      m_held = 1;
      done = 0;
      while (!done) begin
        do begin
          tick(rs);
          if (abort) return;
        end while (rs != 4'hF);
        quiet = 0;
        while (quiet < DC) begin
          tick(rs);
          if (abort) return;
          if (rs != 4'hF) break;
          quiet++;
        end
        if (quiet == DC) done = 1;
      end
      m_held = 0;
      m_col = (m_col + 1) % 5;
    end
  endtask

  initial begin
    forever begin
      m_reset();
      wait (rst === 1'b1);
      abort = 0;
      run_model();
    end
  end

  // ---------------- per-cycle compare + pulse monitor ----------------
  int         dut_pulses = 0;
  logic [4:0] exp_col;

  always @(negedge clk) begin
    if (cifra_noua === 1'b1) dut_pulses++;
    if (chk_en) begin
      exp_col = ~(5'd1 << m_col);
      cmp("col_out", 32'(col_out), 32'(exp_col));
      cmp("data", 32'(data), 32'(m_data));
      cmp("cifra_noua", 32'(cifra_noua), 32'(m_stb));
      cmp("key_held", 32'(key_held), 32'(m_held));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic wait_pulse(input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (cifra_noua === 1'b1) begin got = 1; break; end
    end
  endtask

  task automatic wait_release(input string name, input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (key_held === 1'b0) begin got = 1; break; end
    end
    if (!got) cmp(name, 32'(key_held), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    int p0, mp0, n, changes, bad;
    logic [4:0] prev;

    // Reset state
    cycles(3);
    chk_en = 1'b1;
    cmp("rst_col_out", 32'(col_out), 32'h1E);
    cmp("rst_data", 32'(data), 32'd0);
    cmp("rst_strobe", 32'(cifra_noua), 32'd0);
    cmp("rst_held", 32'(key_held), 32'd0);
    rst = 1'b1;
    cycles(5);

    // k=7 (col1,row3): latency, single pulse, release returns scan to column 2
    p0 = dut_pulses; mp0 = m_pulses;
    keys[7] = 1'b1;
    got = 0;
    for (int i = 0; i < 200; i++) begin step(); if (m_in_db) begin got = 1; break; end end
    cmp("k7_captured", 32'(got), 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin step(); n++; if (cifra_noua === 1'b1) break; end
    cmp("k7_latency", 32'(n), 32'(DC));
    cmp("k7_data", 32'(data), 32'd7);
    cmp("k7_held", 32'(key_held), 32'd1);
    cycles(100);
    keys = '0;
    wait_release("k7_release", 60);
    cmp("k7_next_col", 32'(col_out), 32'h1B);
    cmp("k7_dut_pulses", 32'(dut_pulses - p0), 32'd1);
    cmp("k7_model_pulses", 32'(m_pulses - mp0), 32'd1);
    cycles(10);

    // k=18 (escape) with a 2-cycle gap right after capture
    p0 = dut_pulses; mp0 = m_pulses;
    keys[KEY_ESCAPE] = 1'b1;
    got = 0;
    for (int i = 0; i < 200; i++) begin step(); if (m_in_db) begin got = 1; break; end end
    cmp("k18_captured", 32'(got), 32'd1);
    keys[KEY_ESCAPE] = 1'b0;
    cycles(2);
    cmp("k18_no_early_pulse", 32'(dut_pulses - p0), 32'd0);
    keys[KEY_ESCAPE] = 1'b1;
    wait_pulse(200, got);
    cmp("k18_seen", 32'(got), 32'd1);
    cmp("k18_data", 32'(data), 32'd18);
    cycles(20);
    cmp("k18_single_pulse", 32'(dut_pulses - p0), 32'd1);
    cmp("k18_model_pulses", 32'(m_pulses - mp0), 32'd1);
    keys = '0;
    wait_release("k18_release", 60);
    cycles(10);

    // k=19: held, no strobe, data kept
    p0 = dut_pulses;
    keys[KEY_NONE] = 1'b1;
    got = 0;
    for (int i = 0; i < 200; i++) begin step(); if (key_held === 1'b1) begin got = 1; break; end end
    cmp("k19_held", 32'(got), 32'd1);
    cycles(20);
    cmp("k19_data_kept", 32'(data), 32'd18);
    cmp("k19_no_pulse", 32'(dut_pulses - p0), 32'd0);
    keys = '0;
    wait_release("k19_release", 60);
    cycles(10);

    // Rows 0 and 1 together in column 2: scanning keeps rotating
    p0 = dut_pulses;
    keys[8] = 1'b1; keys[9] = 1'b1;
    changes = 0; bad = 0; prev = col_out;
    for (int i = 0; i < 80; i++) begin
      step();
      if (key_held !== 1'b0) bad++;
      if (col_out !== prev) begin
        changes++;
        if (col_out !== {prev[3:0], prev[4]}) bad++;
        prev = col_out;
      end
    end
    cmp("ghost_rotation_ok", 32'(bad), 32'd0);
    cmp("ghost_rotating", 32'(changes >= 15), 32'd1);
    cmp("ghost_no_pulse", 32'(dut_pulses - p0), 32'd0);
    keys = '0;
    cycles(10);

    // k=11 held, k=4 pressed meanwhile, both released together
    p0 = dut_pulses;
    keys[KEY_PLUS] = 1'b1;
    wait_pulse(200, got);
    cmp("k11_seen", 32'(got), 32'd1);
    cmp("k11_data", 32'(data), 32'd11);
    keys[4] = 1'b1;
    cycles(40);
    keys = '0;
    wait_release("k11_release", 60);
    cycles(40);
    cmp("k11_k4_one_pulse", 32'(dut_pulses - p0), 32'd1);
    cmp("k11_data_kept", 32'(data), 32'd11);

    // k=11 held, k=4 pressed, k=11 released first: k=4 follows after full release
    keys[KEY_PLUS] = 1'b1;
    wait_pulse(200, got);
    cmp("k11b_seen", 32'(got), 32'd1);
    keys[4] = 1'b1;
    cycles(30);
    keys[KEY_PLUS] = 1'b0;
    wait_pulse(200, got);
    cmp("k4_after_release", 32'(got), 32'd1);
    cmp("k4_data", 32'(data), 32'd4);
    keys = '0;
    wait_release("k4_release", 60);
    cycles(10);

    // Reset while k=5 is held, then re-detection
    keys[5] = 1'b1;
    wait_pulse(200, got);
    cmp("k5_seen", 32'(got), 32'd1);
    cycles(10);
    #1 rst = 1'b0;
    #1;
    cmp("k5_rst_col_out", 32'(col_out), 32'h1E);
    cmp("k5_rst_data", 32'(data), 32'd0);
    cmp("k5_rst_strobe", 32'(cifra_noua), 32'd0);
    cmp("k5_rst_held", 32'(key_held), 32'd0);
    cycles(2);
    rst = 1'b1;
    p0 = dut_pulses;
    wait_pulse(200, got);
    cmp("k5_redetect", 32'(got), 32'd1);
    cmp("k5_redetect_data", 32'(data), 32'd5);
    cycles(20);
    cmp("k5_one_pulse", 32'(dut_pulses - p0), 32'd1);
    keys = '0;
    wait_release("k5_release", 60);
    cycles(10);

    // Random presses with bounce and overlapping second keys
    for (int it = 0; it < 30; it++) begin
      int k, k2;
      k = ($urandom_range(0, 3) == 0) ? int'(OPS[$urandom_range(0, 8)]) : int'($urandom_range(0, 19));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin
          keys[k] = 1'b1; cycles($urandom_range(1, 3));
          keys[k] = 1'b0; cycles($urandom_range(1, 2));
        end
      end
      keys[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        cycles($urandom_range(0, 20));
        k2 = $urandom_range(0, 19);
        keys[k2] = 1'b1;
      end
      cycles($urandom_range(5, 80));
      keys = '0;
      wait_release("rnd_release", 60);
      cycles($urandom_range(0, 25));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
